// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: default payload width and
// the field layout of the memory-stage payload it usually carries.
package pipe_pkg;

    localparam int PAYLOAD_W_DEF = 40;

    localparam int ALU_W  = 16;
    localparam int RD_W   = 3;
    localparam int WE_W   = 1;
    localparam int BP_W   = 2;
    localparam int SD_W   = 16;
    localparam int LS_W   = 2;

    localparam int ALU_OFF = 0;
    localparam int RD_OFF  = ALU_OFF + ALU_W;
    localparam int WE_OFF  = RD_OFF + RD_W;
    localparam int BP_OFF  = WE_OFF + WE_W;
    localparam int SD_OFF  = BP_OFF + BP_W;
    localparam int LS_OFF  = SD_OFF + SD_W;
    localparam int MEM_PAYLOAD_W = LS_OFF + LS_W;

    // Packed order puts the last field at the MSB end, matching the offsets above.
    typedef struct packed {
        logic [LS_W-1:0]  ls_en;
        logic [SD_W-1:0]  store_data;
        logic [BP_W-1:0]  bp;
        logic [WE_W-1:0]  we;
        logic [RD_W-1:0]  rd;
        logic [ALU_W-1:0] alu;
    } mem_payload_t;

    function automatic logic [MEM_PAYLOAD_W-1:0] mem_pack(input mem_payload_t p);
        return p;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the elastic stage: a valid bit and a data register that
// loads only when told to and is squashed by a synchronous clear.
module pipe_slot #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         valid_d_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Valid and data state; a clear beats both the next-valid and the load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= clr_i ? 1'b0 : valid_d_i;
            if (load_i && !clr_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 out_ready,
    input  logic                 flush,
    input  logic                 stall_cnt_clr,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic                 main_v;
    logic [PAYLOAD_W-1:0] main_data;
    logic                 accept_s;
    logic                 release_s;
    logic                 main_valid_d;
    logic                 main_load_s;
    logic [PAYLOAD_W-1:0] main_data_d;
    logic [CNT_W-1:0]     stall_cnt_q;
    logic [CNT_W-1:0]     stall_cnt_d;

`ifdef PIPE_STAGE_SKID_EN
    logic                 skid_v;
    logic [PAYLOAD_W-1:0] skid_data;
    logic                 skid_valid_d;
    logic                 skid_load_s;

    // in_ready comes straight from the skid valid register: no path from out_ready.
    assign in_ready = ~skid_v;

    // Main/skid steering: on release skid refills main; otherwise overflow goes to skid.
    always_comb begin
        accept_s     = in_valid & ~skid_v;
        release_s    = main_v & out_ready;
        main_valid_d = main_v;
        main_load_s  = 1'b0;
        main_data_d  = in_data;
        skid_valid_d = skid_v;
        skid_load_s  = 1'b0;
        if (release_s) begin
            if (skid_v) begin
                main_valid_d = 1'b1;
                main_load_s  = 1'b1;
                main_data_d  = skid_data;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                main_valid_d = 1'b1;
                main_load_s  = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            if (main_v) begin
                skid_valid_d = 1'b1;
                skid_load_s  = 1'b1;
            end else begin
                main_valid_d = 1'b1;
                main_load_s  = 1'b1;
            end
        end else begin
            main_valid_d = main_v;
        end
    end

    pipe_slot #(.W(PAYLOAD_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (flush),
        .valid_d_i (skid_valid_d),
        .load_i    (skid_load_s),
        .data_i    (in_data),
        .valid_o   (skid_v),
        .data_o    (skid_data)
    );

    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
`else
    assign in_ready = ~main_v | out_ready;

    // Single entry: an accept always lands in main, replacing a released payload.
    always_comb begin
        accept_s     = in_valid & in_ready;
        release_s    = main_v & out_ready;
        main_load_s  = accept_s;
        main_data_d  = in_data;
        if (accept_s) begin
            main_valid_d = 1'b1;
        end else if (release_s) begin
            main_valid_d = 1'b0;
        end else begin
            main_valid_d = main_v;
        end
    end

    assign occupancy = {1'b0, main_v};
`endif

    pipe_slot #(.W(PAYLOAD_W)) u_main (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (flush),
        .valid_d_i (main_valid_d),
        .load_i    (main_load_s),
        .data_i    (main_data_d),
        .valid_o   (main_v),
        .data_o    (main_data)
    );

    assign out_valid = main_v;
    assign out_data  = main_data;

    // Stall counter next state: clear wins, otherwise count held-off cycles up to all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (main_v && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 The block SHALL have parameter PAYLOAD_W, default 40, giving the width of the carried payload in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the stall counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the producer presents a payload.
REQ-006 The block SHALL have port in_data, input, PAYLOAD_W, the producer payload.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the stage accepts in_data this cycle.
REQ-008 The block SHALL have port out_valid, output, 1, meaning out_data holds a live payload.
REQ-009 The block SHALL have port out_data, output, PAYLOAD_W, the consumer payload.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes out_data this cycle.
REQ-011 The block SHALL have port flush, input, 1, a synchronous squash of all held payloads.
REQ-012 The block SHALL have port stall_cnt_clr, input, 1, a synchronous clear of the stall counter.
REQ-013 The block SHALL have port occupancy, output, 2, the number of live entries (0..1, or 0..2 with skid).
REQ-014 The block SHALL have port stall_cnt, output, CNT_W, a saturating count of back-pressured cycles.

Function
REQ-015 Accept SHALL occur when in_valid and in_ready are both 1 at a clk edge; a payload accepted at edge N SHALL appear on out_data with out_valid=1 after edge N (latency 1).
REQ-016 Release SHALL occur when out_valid and out_ready are both 1 at an edge; payloads SHALL leave in acceptance order with no loss or duplication.
REQ-017 Simultaneous accept and release on a full single entry SHALL replace the entry with no bubble cycle.
REQ-018 When flush=1 at an edge, all entries SHALL become invalid after that edge, and any payload offered that cycle SHALL be dropped; flush SHALL take priority over accept and release.
REQ-019 While out_valid=0, out_data SHALL hold its last value; data registers SHALL load only on accept.
REQ-020 stall_cnt SHALL increment on every edge with out_valid=1 and out_ready=0, and SHALL saturate at 2^CNT_W-1.
REQ-021 When stall_cnt_clr=1, stall_cnt SHALL be 0 after that edge, overriding any increment in the same cycle.
REQ-022 occupancy SHALL equal the count of valid entries after each edge.

Reset
REQ-023 While reset=1, out_valid, all internal valid bits, occupancy and stall_cnt SHALL be 0, and out_data and skid data SHALL be all-zero, independently of clk.
REQ-024 Reset asserted mid-transfer SHALL discard all entries; the first accept after reset release SHALL behave as from empty.

Configuration
REQ-025 Macro PIPE_STAGE_SKID_EN SHALL select the buffering mode.
REQ-026 Without PIPE_STAGE_SKID_EN: one entry; in_ready = ~out_valid | out_ready (combinational from out_ready); occupancy max 1.
REQ-027 With PIPE_STAGE_SKID_EN: main entry plus one skid entry; in_ready SHALL be a registered value, equal to ~skid_valid, with no combinational path from out_ready.
REQ-028 With PIPE_STAGE_SKID_EN: an accept while main is valid and not released SHALL go to skid; on release, skid SHALL move to main in the same edge; occupancy max 2.

Structure
REQ-029 Shared package pipe_pkg SHALL hold the default PAYLOAD_W (40) and the field offset/width constants of the memory-stage payload: alu result 16, destination register address 3, write enable 1, bp 2, store data 16, load/store enable 2.
REQ-030 One sub-module, pipe_slot (valid bit plus PAYLOAD_W data register with load and clear), SHALL be instantiated once, or twice with skid.

Verification
REQ-031 Reset, then in_valid=1, in_data=40'h12345_6789A, out_ready=1 -> one cycle later out_valid=1, out_data=40'h12345_6789A, occupancy=1.
REQ-032 Stream 8 payloads 0..7 with out_ready=1 -> received 0..7 in order at one per cycle in both modes.
REQ-033 With skid, hold out_ready=0 and offer 3 payloads A,B,C -> A and B accepted, in_ready=0 from the third edge, occupancy=2, stall_cnt increments each cycle; raise out_ready -> A then B released.
REQ-034 With occupancy=2, assert flush together with in_valid=1 -> next cycle out_valid=0, occupancy=0, offered payload never appears.
REQ-035 With CNT_W=4, hold a stall for 20 cycles -> stall_cnt=15; then assert stall_cnt_clr during the stall -> stall_cnt=0.
REQ-036 Assert reset between clk edges while occupancy=1 -> out_valid, occupancy and stall_cnt are 0 immediately, out_data=0.
